// File: rtl/mips_pkg.sv
// Opcode constants and multiplier sequencer state type shared across the pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_step_datapath.sv
// One shift-add step of the iterative multiplier, retiring BITS_PER_CYCLE multiplier bits.
module mul_step_datapath #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0] mplier_o
);

    always_comb begin
        acc_o = acc_i;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_i[i]) begin
                acc_o = acc_o + (mcand_i << i);
            end
        end
    end

    assign mcand_o  = mcand_i << BITS_PER_CYCLE;
    assign mplier_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/mul_stall_sequencer.sv
// EX-stage MUL sequencer: stalls the front of the pipeline while a shift-add multiply runs,
// then presents the low WIDTH bits of the product for one cycle.
module mul_stall_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mul_req,
    input  logic             flush,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    mul_state_t       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] acc_d, mcand_d, mplier_d;

    mul_step_datapath #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_d),
        .mcand_o  (mcand_d),
        .mplier_o (mplier_d)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_req && !flush) begin
                        mcand_q  <= srca;
                        mplier_q <= srcb;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        count_q  <= count_q + 1'b1;
                        if (count_q == CNT_W'(N - 1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                // mul_req here belongs to the retiring MUL, so never restart from DONE
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset_n so a request held during reset never raises stall or a stale pulse.
    assign stall        = reset_n && !flush &&
                          ((state_q == IDLE && mul_req) || state_q == BUSY);
    assign busy         = (state_q == BUSY);
    assign result_valid = reset_n && !flush && (state_q == DONE);
    assign result       = acc_q;

endmodule

// File: tb/tb_mul_stall_sequencer.sv
// Randomized self-checking bench for mul_stall_sequencer (BITS_PER_CYCLE=1 and 4 instances).
module tb_mul_stall_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0, fl = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        stall, busy, rv;
    logic [31:0] res;

    logic        req4 = 1'b0, fl4 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0;
    logic        stall4, busy4, rv4;
    logic [31:0] res4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] op_a[$], op_b[$], got_res[$];
    int          got_cyc[$];
    int          tot_stall, tot_busy, extra;

    always #5 clk = ~clk;

    mul_stall_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .mul_req(req), .flush(fl), .srca(a), .srcb(b),
        .stall(stall), .busy(busy), .result_valid(rv), .result(res)
    );

    mul_stall_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .mul_req(req4), .flush(fl4), .srca(a4), .srcb(b4),
        .stall(stall4), .busy(busy4), .result_valid(rv4), .result(res4)
    );

    function automatic logic [31:0] model_mul(input logic [31:0] x, input logic [31:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives op_a/op_b as consecutive MULs, advancing operands after each result pulse.
    task automatic run_ops();
        int k = 0;
        int cyc = 0;
        int n = op_a.size();
        got_res.delete();
        got_cyc.delete();
        tot_stall = 0;
        tot_busy = 0;
        extra = 0;
        req = 1'b1;
        a = op_a[0];
        b = op_b[0];
        while (k < n && cyc < 100 * n + 100) begin
            @(negedge clk);
            if (stall) tot_stall++;
            if (busy) tot_busy++;
            if (rv) begin
                got_res.push_back(res);
                got_cyc.push_back(cyc);
                k++;
            end
            tick();
            cyc++;
            if (k < n) begin
                a = op_a[k];
                b = op_b[k];
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall || rv || busy) extra++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 1'b1;
        a = 32'd7;
        b = 32'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
            n_checks++; if (rv !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rv); else n_pass++;
            n_checks++; if (res !== 32'd0) $display("FAIL reset_result got=%0d exp=0", res); else n_pass++;
        end
        tick();
        req = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        op_a = '{32'd7};
        op_b = '{32'd6};
        run_ops();
        n_checks++; if (got_res.size() !== 1) $display("FAIL basic_pulses got=%0d exp=1", got_res.size()); else n_pass++;
        if (got_res.size() > 0) begin
            n_checks++; if (got_res[0] !== 32'd42) $display("FAIL basic_result got=%0d exp=42", got_res[0]); else n_pass++;
            n_checks++; if (got_cyc[0] !== 33) $display("FAIL basic_latency got=%0d exp=33", got_cyc[0]); else n_pass++;
        end
        n_checks++; if (tot_stall !== 33) $display("FAIL basic_stall got=%0d exp=33", tot_stall); else n_pass++;
        n_checks++; if (tot_busy !== 32) $display("FAIL basic_busy got=%0d exp=32", tot_busy); else n_pass++;
        n_checks++; if (extra !== 0) $display("FAIL basic_after_idle got=%0d exp=0", extra); else n_pass++;
    endtask

    task automatic test_truncation();
        logic [31:0] exp_r [2] = '{32'h00000001, 32'h00000000};
        logic [31:0] ta [2] = '{32'hFFFFFFFF, 32'h80000000};
        logic [31:0] tb [2] = '{32'hFFFFFFFF, 32'h00000002};
        for (int i = 0; i < 2; i++) begin
            op_a = '{ta[i]};
            op_b = '{tb[i]};
            run_ops();
            n_checks++;
            if (got_res.size() != 1 || got_res[0] !== exp_r[i])
                $display("FAIL trunc_%0d got=%h (pulses=%0d) exp=%h", i,
                         (got_res.size() > 0) ? got_res[0] : 32'hx, got_res.size(), exp_r[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        op_a = '{32'd3, 32'd10};
        op_b = '{32'd5, 32'd10};
        run_ops();
        n_checks++; if (got_res.size() !== 2) $display("FAIL b2b_pulses got=%0d exp=2", got_res.size()); else n_pass++;
        if (got_res.size() == 2) begin
            n_checks++; if (got_res[0] !== 32'd15) $display("FAIL b2b_first got=%0d exp=15", got_res[0]); else n_pass++;
            n_checks++; if (got_res[1] !== 32'd100) $display("FAIL b2b_second got=%0d exp=100", got_res[1]); else n_pass++;
            n_checks++; if (got_cyc[1] - got_cyc[0] !== 34)
                $display("FAIL b2b_spacing got=%0d exp=34", got_cyc[1] - got_cyc[0]); else n_pass++;
        end
        n_checks++; if (tot_stall !== 66) $display("FAIL b2b_stall got=%0d exp=66", tot_stall); else n_pass++;
        n_checks++; if (extra !== 0) $display("FAIL b2b_after_idle got=%0d exp=0", extra); else n_pass++;
    endtask

    // mode 0: flush at BUSY count=10; mode 1: reset at the same point
    task automatic test_abort(input int mode);
        int pulses = 0;
        int stalls = 0;
        req = 1'b1;
        a = 32'd1234;
        b = 32'd5678;
        for (int i = 0; i < 11; i++) tick();
        if (mode == 0) fl = 1'b1; else reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) $display("FAIL abort%0d_stall got=%b exp=0", mode, stall); else n_pass++;
        n_checks++; if (rv !== 1'b0) $display("FAIL abort%0d_valid got=%b exp=0", mode, rv); else n_pass++;
        tick();
        fl = 1'b0;
        reset_n = 1'b1;
        req = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort%0d_busy got=%b exp=0", mode, busy); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rv) pulses++;
            if (stall) stalls++;
            tick();
        end
        n_checks++; if (pulses !== 0) $display("FAIL abort%0d_pulse got=%0d exp=0", mode, pulses); else n_pass++;
        n_checks++; if (stalls !== 0) $display("FAIL abort%0d_stalls got=%0d exp=0", mode, stalls); else n_pass++;
        op_a = '{32'd9};
        op_b = '{32'd9};
        run_ops();
        n_checks++;
        if (got_res.size() != 1 || got_res[0] !== 32'd81)
            $display("FAIL abort%0d_next got=%0d (pulses=%0d) exp=81", mode,
                     (got_res.size() > 0) ? got_res[0] : 32'hx, got_res.size());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            op_a = '{$urandom()};
            op_b = '{$urandom()};
            if (i == 5) begin
                op_a.push_back($urandom());
                op_b.push_back($urandom());
                op_a.push_back($urandom_range(0, 255));
                op_b.push_back(32'd0);
            end
            run_ops();
            n_checks++;
            if (got_res.size() !== op_a.size())
                $display("FAIL rand_%0d_pulses got=%0d exp=%0d", i, got_res.size(), op_a.size());
            else n_pass++;
            for (int k = 0; k < got_res.size() && k < op_a.size(); k++) begin
                n_checks++;
                if (got_res[k] !== model_mul(op_a[k], op_b[k]))
                    $display("FAIL rand_%0d_%0d got=%h exp=%h", i, k, got_res[k], model_mul(op_a[k], op_b[k]));
                else n_pass++;
            end
            n_checks++;
            if (tot_stall !== 33 * op_a.size())
                $display("FAIL rand_%0d_stall got=%0d exp=%0d", i, tot_stall, 33 * op_a.size());
            else n_pass++;
        end
    endtask

    task automatic test_bpc4();
        logic [31:0] xa [3] = '{32'd12345, 32'd0, 32'd0};
        logic [31:0] xb [3] = '{32'd678, 32'd0, 32'd0};
        xa[1] = $urandom();
        xb[1] = $urandom();
        xa[2] = 32'hFFFFFFFF;
        xb[2] = $urandom();
        for (int i = 0; i < 3; i++) begin
            int stalls = 0;
            int pulses = 0;
            int cyc = 0;
            logic [31:0] got = '0;
            req4 = 1'b1;
            a4 = xa[i];
            b4 = xb[i];
            while (pulses == 0 && cyc < 50) begin
                @(negedge clk);
                if (stall4) stalls++;
                if (rv4) begin
                    pulses++;
                    got = res4;
                end
                tick();
                cyc++;
            end
            req4 = 1'b0;
            n_checks++; if (pulses !== 1) $display("FAIL bpc4_%0d_pulse got=%0d exp=1", i, pulses); else n_pass++;
            n_checks++; if (got !== model_mul(xa[i], xb[i]))
                $display("FAIL bpc4_%0d_result got=%0d exp=%0d", i, got, model_mul(xa[i], xb[i])); else n_pass++;
            n_checks++; if (stalls !== 9) $display("FAIL bpc4_%0d_stall got=%0d exp=9", i, stalls); else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_back_to_back();
        test_abort(0);
        test_abort(1);
        test_random();
        test_bpc4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
